// File: rtl/calendar_pkg.sv
// calendar_pkg: parser state, ASCII constants and calendar helpers shared by uart_cmd_parser.
package calendar_pkg;
  typedef enum logic [1:0] {IDLE, DIGITS, TERM, CHECK} state_e;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_T  = 8'h54;
  localparam logic [7:0] ASCII_TL = 8'h74;
  localparam logic [7:0] ASCII_D  = 8'h44;
  localparam logic [7:0] ASCII_DL = 8'h64;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_E  = 8'h45;
  function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic [6:0] year);
    return (month == 4'd2) ? ((year[1:0] == 2'b00) ? 5'd29 : 5'd28) :
           (month == 4'd4 || month == 4'd6 || month == 4'd9 || month == 4'd11) ? 5'd30 : 5'd31;
  endfunction
  function automatic logic [6:0] bcd2bin(input logic [3:0] tens, input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction
endpackage

// File: rtl/inter_byte_timer.sv
// inter_byte_timer: countdown of the allowed gap between bytes of a frame.
module inter_byte_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  input  logic run,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = reload ? W'(TIMEOUT_CYCLES - 1) : (run && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign expired = run && cnt_q == '0;
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes "T/D + 6 digits + CR/LF" set-commands into calendar load strobes.
// Define UART_CMD_ACK_EN to add a single-entry K/E acknowledge register toward the UART transmitter.
module uart_cmd_parser import calendar_pkg::*; #(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned TIMEOUT_MS     = 10,
  parameter int unsigned TIMEOUT_CYCLES = CLK_HZ / 1000 * TIMEOUT_MS
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_break,
  output logic       time_load,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic       date_load,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic       cmd_error,
  output logic       busy
`ifdef UART_CMD_ACK_EN
  , output logic       ack_valid
  , output logic [7:0] ack_data
  , input  logic       ack_ready
`endif
);
  state_e state_q, state_d;
  logic is_date_q, is_date_d;
  logic [2:0] cnt_q, cnt_d;
  logic [5:0][3:0] dig_q, dig_d;
  logic time_load_q, time_load_d, date_load_q, date_load_d, cmd_error_q, cmd_error_d;
  logic [4:0] hour_q, day_q;
  logic [5:0] minute_q, second_q;
  logic [3:0] month_q;
  logic [6:0] year_q;
  logic is_cmd, is_digit, is_term, expired, abort, take_digit;
  logic [6:0] f0, f1, f2;
  logic time_ok, date_ok, ok;

  assign is_cmd     = rx_data == ASCII_T || rx_data == ASCII_TL || rx_data == ASCII_D || rx_data == ASCII_DL;
  assign is_digit   = rx_data >= ASCII_0 && rx_data <= ASCII_9;
  assign is_term    = rx_data == ASCII_CR || rx_data == ASCII_LF;
  assign abort      = state_q != IDLE && rx_break;
  assign take_digit = state_q == DIGITS && rx_valid && is_digit && !rx_break;

  inter_byte_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (CLK),
    .rst     (reset),
    .reload  (rx_valid || state_q == IDLE),
    .run     (state_q == DIGITS || state_q == TERM),
    .expired (expired)
  );

  // Field order in the buffer is hh/mm/ss for time and dd/mm/yy for date.
  assign f0      = bcd2bin(dig_q[0], dig_q[1]);
  assign f1      = bcd2bin(dig_q[2], dig_q[3]);
  assign f2      = bcd2bin(dig_q[4], dig_q[5]);
  assign time_ok = f0 < 7'd24 && f1 < 7'd60 && f2 < 7'd60;
  assign date_ok = f1 >= 7'd1 && f1 <= 7'd12 && f0 >= 7'd1 && f0 <= {2'b00, days_in_month(f1[3:0], f2)};
  assign ok      = is_date_q ? date_ok : time_ok;

  always_ff @(posedge CLK) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    state_d = (rx_valid && is_cmd) ? DIGITS : IDLE;
        DIGITS:  state_d = rx_valid ? (!is_digit ? IDLE : (cnt_q == 3'd5) ? TERM : DIGITS) : expired ? IDLE : DIGITS;
        TERM:    state_d = rx_valid ? (is_term ? CHECK : IDLE) : expired ? IDLE : TERM;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_error_d = abort ||
                  (state_q == DIGITS && (rx_valid ? !is_digit : expired)) ||
                  (state_q == TERM && (rx_valid ? !is_term : expired)) ||
                  (state_q == CHECK && !ok);
    time_load_d = state_q == CHECK && !rx_break && ok && !is_date_q;
    date_load_d = state_q == CHECK && !rx_break && ok && is_date_q;
  end

  always_comb begin
    is_date_d = (state_q == IDLE && rx_valid && is_cmd) ? (rx_data == ASCII_D || rx_data == ASCII_DL) : is_date_q;
    cnt_d     = (state_q == IDLE) ? 3'd0 : take_digit ? cnt_q + 3'd1 : cnt_q;
    dig_d     = dig_q;
    if (take_digit) dig_d[cnt_q] = rx_data[3:0];
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      is_date_q   <= 1'b0;
      cnt_q       <= '0;
      dig_q       <= '0;
      time_load_q <= 1'b0;
      date_load_q <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      is_date_q   <= is_date_d;
      cnt_q       <= cnt_d;
      dig_q       <= dig_d;
      time_load_q <= time_load_d;
      date_load_q <= date_load_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      hour_q   <= '0;
      minute_q <= '0;
      second_q <= '0;
      day_q    <= '0;
      month_q  <= '0;
      year_q   <= '0;
    end else begin
      if (time_load_d) begin
        hour_q   <= f0[4:0];
        minute_q <= f1[5:0];
        second_q <= f2[5:0];
      end
      if (date_load_d) begin
        day_q   <= f0[4:0];
        month_q <= f1[3:0];
        year_q  <= f2;
      end
    end
  end

  assign time_load = time_load_q;
  assign date_load = date_load_q;
  assign cmd_error = cmd_error_q;
  assign hour      = hour_q;
  assign minute    = minute_q;
  assign second    = second_q;
  assign day       = day_q;
  assign month     = month_q;
  assign year      = year_q;
  assign busy      = state_q != IDLE;

`ifdef UART_CMD_ACK_EN
  logic ack_valid_q;
  logic [7:0] ack_data_q;
  // A fresh result overwrites a pending one even if it is being accepted this cycle.
  always_ff @(posedge CLK) begin
    if (reset) begin
      ack_valid_q <= 1'b0;
      ack_data_q  <= '0;
    end else if (cmd_error_d || time_load_d || date_load_d) begin
      ack_valid_q <= 1'b1;
      ack_data_q  <= cmd_error_d ? ASCII_E : ASCII_K;
    end else if (ack_ready) ack_valid_q <= 1'b0;
  end
  assign ack_valid = ack_valid_q;
  assign ack_data  = ack_data_q;
`endif
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: random and directed frames checked against a frame-level reference model.
module tb_uart_cmd_parser;
  localparam int TO = 100;
  logic CLK = 1'b0;
  logic reset = 1'b1, rx_valid = 1'b0, rx_break = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic time_load, date_load, cmd_error, busy;
  logic [4:0] hour, day;
  logic [5:0] minute, second;
  logic [3:0] month;
  logic [6:0] year;
  logic ack_ready = 1'b0;
  bit ack_rand = 1'b0;
`ifdef UART_CMD_ACK_EN
  logic ack_valid;
  logic [7:0] ack_data;
`endif

  always #5 CLK = ~CLK;

  uart_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
`ifdef UART_CMD_ACK_EN
    .ack_valid(ack_valid), .ack_data(ack_data), .ack_ready(ack_ready),
`endif
    .CLK(CLK), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_break(rx_break),
    .time_load(time_load), .hour(hour), .minute(minute), .second(second),
    .date_load(date_load), .day(day), .month(month), .year(year),
    .cmd_error(cmd_error), .busy(busy)
  );

  int checks = 0, errors = 0;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: 0 = waiting for command, 1 = collecting, 2 = frame complete, being judged
  int cyc = 0, mode = 0, last = 0;
  logic [7:0] cmd;
  logic [7:0] digs[$];
  bit e_tl, e_dl, e_err, e_av;
  logic [7:0] e_ad;
  logic [4:0] e_hour, e_day;
  logic [5:0] e_min, e_sec;
  logic [3:0] e_mon;
  logic [6:0] e_year;
  int dim [1:12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  function automatic bit cmd_char(logic [7:0] d);
    return d == "T" || d == "t" || d == "D" || d == "d";
  endfunction

  task automatic judge();
    int a, b, c;
    bit good;
    a = (digs[0] - 48) * 10 + (digs[1] - 48);
    b = (digs[2] - 48) * 10 + (digs[3] - 48);
    c = (digs[4] - 48) * 10 + (digs[5] - 48);
    if (cmd == "D" || cmd == "d") begin
      good = b >= 1 && b <= 12 && a >= 1;
      if (good) good = a <= ((b == 2 && c % 4 == 0) ? 29 : dim[b]);
      if (good) begin e_dl = 1; e_day = 5'(a); e_mon = 4'(b); e_year = 7'(c); end
    end else begin
      good = a < 24 && b < 60 && c < 60;
      if (good) begin e_tl = 1; e_hour = 5'(a); e_min = 6'(b); e_sec = 6'(c); end
    end
    e_err = !good;
  endtask

  task automatic step(bit v, logic [7:0] d, bit b);
    rx_valid = v; rx_data = d; rx_break = b;
    if (ack_rand) ack_ready = 1'($urandom_range(0, 1));
    @(posedge CLK);
    e_tl = 0; e_dl = 0; e_err = 0;
    if (mode == 0) begin
      if (v && cmd_char(d)) begin mode = 1; cmd = d; digs.delete(); last = cyc; end
    end else if (mode == 1) begin
      if (b) begin e_err = 1; mode = 0; end
      else if (v) begin
        last = cyc;
        if (digs.size() < 6) begin
          if (d >= "0" && d <= "9") digs.push_back(d);
          else begin e_err = 1; mode = 0; end
        end else if (d == 8'h0D || d == 8'h0A) mode = 2;
        else begin e_err = 1; mode = 0; end
      end else if (cyc - last == TO) begin e_err = 1; mode = 0; end
    end else begin
      mode = 0;
      if (b) e_err = 1;
      else judge();
    end
    if (e_tl || e_dl || e_err) begin e_av = 1; e_ad = e_err ? 8'h45 : 8'h4B; end
    else if (ack_ready) e_av = 0;
    cyc++;
    #1;
    check("strobes", {time_load, date_load, cmd_error}, {e_tl, e_dl, e_err});
    check("busy", busy, mode != 0);
    check("fields", {hour, minute, second, day, month, year}, {e_hour, e_min, e_sec, e_day, e_mon, e_year});
`ifdef UART_CMD_ACK_EN
    check("ack", {ack_valid, ack_data}, {e_av, e_ad});
`endif
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 8'h00, 0);
  endtask

  task automatic send(string s);
    for (int i = 0; i < s.len(); i++) step(1, s[i], 0);
  endtask

  task automatic do_reset();
    reset = 1; rx_valid = 0; rx_break = 0; rx_data = 0;
    @(posedge CLK);
    #1;
    reset = 0;
    mode = 0; cyc++;
    e_tl = 0; e_dl = 0; e_err = 0; e_av = 0; e_ad = 0;
    e_hour = 0; e_min = 0; e_sec = 0; e_day = 0; e_mon = 0; e_year = 0;
    check("reset_outputs", {time_load, date_load, cmd_error, busy}, 4'b0000);
    check("reset_fields", {hour, minute, second, day, month, year}, 64'd0);
  endtask

  task automatic push2(inout logic [7:0] q[$], input int x);
    q.push_back(8'(48 + x / 10));
    q.push_back(8'(48 + x % 10));
  endtask

  task automatic rand_frame();
    logic [7:0] q[$];
    logic [7:0] c;
    int g;
    c = ($urandom_range(0, 15) == 0) ? 8'($urandom) : ($urandom_range(0, 1) ? "T" : "D");
    if ($urandom_range(0, 1)) c = (c == "T") ? "t" : (c == "D") ? "d" : c;
    q.push_back(c);
    if (c == "D" || c == "d") begin
      push2(q, $urandom_range(0, 32)); push2(q, $urandom_range(0, 13)); push2(q, $urandom_range(0, 99));
    end else begin
      push2(q, $urandom_range(0, 25)); push2(q, $urandom_range(0, 61)); push2(q, $urandom_range(0, 61));
    end
    q.push_back(($urandom_range(0, 9) == 0) ? 8'($urandom) : ($urandom_range(0, 1) ? 8'h0D : 8'h0A));
    if ($urandom_range(0, 9) == 0) q[$urandom_range(1, q.size() - 1)] = 8'($urandom);
    foreach (q[i]) begin
      step(1, q[i], $urandom_range(0, 79) == 0);
      g = ($urandom_range(0, 24) == 0) ? $urandom_range(98, 101) : $urandom_range(0, 2);
      repeat (g) step(0, 8'h00, $urandom_range(0, 199) == 0);
    end
    idle($urandom_range(0, 3));
  endtask

  initial begin
    do_reset();
    idle(2);
    send("T235959\r"); idle(3);
    check("t_fields", {hour, minute, second}, {5'd23, 6'd59, 6'd59});
    send("D290224\n"); idle(3);
    check("d_fields", {day, month, year}, {5'd29, 4'd2, 7'd24});
    send("D290223\r"); idle(3);
    check("d_kept", {day, month, year}, {5'd29, 4'd2, 7'd24});
    send("T12a456\r"); idle(2);
    send("x\rT000000\r"); idle(3);
    check("t_zero", {hour, minute, second}, 17'd0);
    send("T12"); idle(TO + 5);
    check("timeout_idle", busy, 1'b0);
    send("T12"); step(0, 8'h00, 1); idle(3);
    send("D01"); step(1, "5", 1); idle(3);
    send("T123"); idle(TO - 1); send("456\r"); idle(3);
    check("gap_boundary", {hour, minute, second}, {5'd12, 6'd34, 6'd56});
    send("D3104"); do_reset(); idle(3);
`ifdef UART_CMD_ACK_EN
    ack_ready = 0;
    send("T010203\r"); idle(4);
    check("ack_k", {ack_valid, ack_data}, {1'b1, 8'h4B});
    send("Tz"); idle(2);
    check("ack_e", {ack_valid, ack_data}, {1'b1, 8'h45});
    ack_ready = 1; idle(1); ack_ready = 0;
    check("ack_clr", ack_valid, 1'b0);
    ack_rand = 1;
`endif
    repeat (300) rand_frame();
    idle(TO + 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
